router_route_unit: RTL and testbench

Parametrised, registered route-computation stage for the mesh NoC router. It replaces the fixed 2x4 `router_sta` lookup: mesh size is generic, multiple input channels are served in parallel, and a valid/ready handshake is provided. Each channel's route is locked per packet, so head flits compute the route and body/tail flits reuse it. It sits between the input buffers and the switch allocator.

---
 rtl/router_route_unit.sv | 163 ++++++++++++++++
 tb/tb_router_route_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_route_unit.sv
// router_route_unit: registered per-channel mesh route computation with the route locked per packet.
// Define ROUTE_YX_EN to add the in_yx port for per-packet YX routing; otherwise routing is always XY.
module router_route_unit #(
    parameter int COLS = 4,
    parameter int ROWS = 2,
    parameter int X_W  = 2,
    parameter int Y_W  = 1,
    parameter int CH   = 5,
    localparam int ADDR_W = X_W + Y_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   router_add,
    input  logic [CH-1:0]       in_valid,
    input  logic [CH-1:0]       in_head,
    input  logic [CH-1:0]       in_tail,
    input  logic [CH*ADDR_W-1:0] in_dst,
`ifdef ROUTE_YX_EN
    input  logic [CH-1:0]       in_yx,
`endif
    output logic [CH-1:0]       in_ready,
    output logic [CH-1:0]       out_valid,
    output logic [CH*3-1:0]     out_port,
    output logic [CH-1:0]       out_tail,
    input  logic [CH-1:0]       out_ready,
    output logic [CH-1:0]       err
);

    localparam logic [2:0] P_LOCAL   = 3'd0;
    localparam logic [2:0] P_NORTH   = 3'd1;
    localparam logic [2:0] P_EAST    = 3'd2;
    localparam logic [2:0] P_SOUTH   = 3'd3;
    localparam logic [2:0] P_WEST    = 3'd4;
    localparam logic [2:0] P_INVALID = 3'd7;

    // ROWS may equal 2^Y_W, so the row limit needs one extra bit.
    localparam logic [Y_W:0] ROWS_LIM = (Y_W+1)'(ROWS);

    typedef enum logic {IDLE, LOCKED} state_t;

    if (COLS != (1 << X_W)) begin : g_bad_cols
        $error("router_route_unit: COLS must equal 2**X_W");
    end

    logic [X_W-1:0] own_x;
    logic [Y_W-1:0] own_y;
    logic [CH-1:0]  yx_sel;

    assign own_x = router_add[X_W-1:0];
    assign own_y = router_add[ADDR_W-1:X_W];

`ifdef ROUTE_YX_EN
    assign yx_sel = in_yx;
`else
    assign yx_sel = '0;
`endif

    function automatic logic [2:0] route_port(
        input logic [X_W-1:0] ox,
        input logic [X_W-1:0] dx,
        input logic [Y_W-1:0] oy,
        input logic [Y_W-1:0] dy,
        input logic           yx
    );
        logic [2:0] px;
        logic [2:0] py;
        px = (dx > ox) ? P_EAST  : (dx < ox) ? P_WEST  : P_LOCAL;
        py = (dy > oy) ? P_SOUTH : (dy < oy) ? P_NORTH : P_LOCAL;
        if (yx) begin
            return (py != P_LOCAL) ? py : px;
        end
        return (px != P_LOCAL) ? px : py;
    endfunction

    for (genvar c = 0; c < CH; c++) begin : g_ch
        state_t         state_q, state_d;
        logic [2:0]     lock_port_q, lock_port_d;
        logic [2:0]     head_port, port_d;
        logic           err_d, accept, y_bad;
        logic [X_W-1:0] dst_x;
        logic [Y_W-1:0] dst_y;
        logic           valid_q, tail_q, err_q;
        logic [2:0]     port_q;

        assign dst_x     = in_dst[c*ADDR_W +: X_W];
        assign dst_y     = in_dst[c*ADDR_W + X_W +: Y_W];
        assign y_bad     = ({1'b0, dst_y} >= ROWS_LIM);
        assign head_port = route_port(own_x, dst_x, own_y, dst_y, yx_sel[c]);

        assign in_ready[c] = !rst && (!valid_q || out_ready[c]);
        assign accept      = in_valid[c] && in_ready[c];

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= IDLE;
                lock_port_q <= 3'd0;
            end else begin
                state_q     <= state_d;
                lock_port_q <= lock_port_d;
            end
        end

        // A head always starts a fresh packet, even when it arrives mid-packet.
        always_comb begin
            state_d     = state_q;
            lock_port_d = lock_port_q;
            if (accept) begin
                if (in_head[c]) begin
                    if (y_bad) begin
                        state_d = IDLE;
                    end else begin
                        lock_port_d = head_port;
                        state_d     = in_tail[c] ? IDLE : LOCKED;
                    end
                end else if (state_q == LOCKED && in_tail[c]) begin
                    state_d = IDLE;
                end
            end
        end

        always_comb begin
            port_d = P_INVALID;
            err_d  = 1'b0;
            if (accept) begin
                if (in_head[c]) begin
                    err_d  = (state_q == LOCKED) || y_bad;
                    port_d = y_bad ? P_INVALID : head_port;
                end else if (state_q == LOCKED) begin
                    port_d = lock_port_q;
                end else begin
                    err_d  = 1'b1;
                end
            end
        end

        // Single output register: holds its flit until the downstream takes it.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                port_q  <= 3'd0;
                tail_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                if (accept) begin
                    valid_q <= 1'b1;
                    port_q  <= port_d;
                    tail_q  <= in_tail[c];
                end else if (out_ready[c]) begin
                    valid_q <= 1'b0;
                end
                if (err_d) begin
                    err_q <= 1'b1;
                end
            end
        end

        assign out_valid[c]       = valid_q;
        assign out_port[c*3 +: 3] = port_q;
        assign out_tail[c]        = tail_q;
        assign err[c]             = err_q;
    end

endmodule

// File: tb/tb_router_route_unit.sv
// Testbench for router_route_unit: directed scenarios plus randomized traffic against a packet-level model.
module tb_router_route_unit;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int X_W  = 2;
    localparam int Y_W  = 2;
    localparam int CH   = 5;
    localparam int AW   = X_W + Y_W;
`ifdef ROUTE_YX_EN
    localparam bit YX_ON = 1'b1;
`else
    localparam bit YX_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   router_add = '0;
    logic [CH-1:0]   in_valid, in_head, in_tail, out_ready, yx_drv;
    logic [CH*AW-1:0] in_dst;
    logic [CH-1:0]   in_ready, out_valid, out_tail, err;
    logic [CH*3-1:0] out_port;

    int checkCount = 0;
    int errCount   = 0;

    bit m_valid[CH];
    bit m_tail[CH];
    bit m_err[CH];
    bit m_locked[CH];
    int m_port[CH];
    int m_lock[CH];

    router_route_unit #(
        .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .CH(CH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .router_add(router_add),
        .in_valid(in_valid),
        .in_head(in_head),
        .in_tail(in_tail),
        .in_dst(in_dst),
`ifdef ROUTE_YX_EN
        .in_yx(yx_drv),
`endif
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_port(out_port),
        .out_tail(out_tail),
        .out_ready(out_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Destination-to-port rule of the mesh, written directly from the direction definitions.
    function automatic int refRoute(int ox, int oy, int dx, int dy, bit yx);
        if (dy >= ROWS) return 7;
        if (yx && dy != oy) return (dy > oy) ? 3 : 1;
        if (dx != ox) return (dx > ox) ? 2 : 4;
        if (dy != oy) return (dy > oy) ? 3 : 1;
        return 0;
    endfunction

    task automatic modelUpdate();
        int  d, p;
        bit  acc;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_valid[c] = 0; m_tail[c] = 0; m_err[c] = 0;
                m_locked[c] = 0; m_port[c] = 0; m_lock[c] = 0;
            end else begin
                acc = in_valid[c] && (!m_valid[c] || out_ready[c]);
                if (acc) begin
                    m_valid[c] = 1;
                    m_tail[c]  = in_tail[c];
                    d = int'(in_dst[c*AW +: AW]);
                    if (in_head[c]) begin
                        if (m_locked[c]) m_err[c] = 1;
                        p = refRoute(int'(router_add) % 4, int'(router_add) / 4,
                                     d % 4, d / 4, YX_ON && yx_drv[c]);
                        m_port[c] = p;
                        if (p == 7) begin
                            m_err[c]    = 1;
                            m_locked[c] = 0;
                        end else begin
                            m_lock[c]   = p;
                            m_locked[c] = !in_tail[c];
                        end
                    end else if (m_locked[c]) begin
                        m_port[c] = m_lock[c];
                        if (in_tail[c]) m_locked[c] = 0;
                    end else begin
                        m_port[c] = 7;
                        m_err[c]  = 1;
                    end
                end else if (out_ready[c]) begin
                    m_valid[c] = 0;
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic runCycle();
        #1;
        for (int c = 0; c < CH; c++)
            checkOutput($sformatf("in_ready[%0d]", c), 32'(in_ready[c]),
                        32'(!rst && (!m_valid[c] || out_ready[c])));
        modelUpdate();
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("out_valid[%0d]", c), 32'(out_valid[c]), 32'(m_valid[c]));
            checkOutput($sformatf("out_port[%0d]", c), 32'(out_port[c*3 +: 3]), 32'(m_port[c]));
            checkOutput($sformatf("out_tail[%0d]", c), 32'(out_tail[c]), 32'(m_tail[c]));
            checkOutput($sformatf("err[%0d]", c), 32'(err[c]), 32'(m_err[c]));
        end
    endtask

    task automatic clearInputs();
        in_valid  = '0;
        in_head   = '0;
        in_tail   = '0;
        in_dst    = '0;
        yx_drv    = '0;
        out_ready = '1;
    endtask

    task automatic setFlit(input int c, input bit head, input bit tail, input int dst, input bit yx);
        in_valid[c]        = 1'b1;
        in_head[c]         = head;
        in_tail[c]         = tail;
        in_dst[c*AW +: AW] = AW'(dst);
        yx_drv[c]          = yx;
    endtask

    task automatic applyStimulus(input int c, input bit head, input bit tail, input int dst, input bit yx);
        clearInputs();
        setFlit(c, head, tail, dst, yx);
        runCycle();
    endtask

    function automatic int portOf(input int c);
        return int'(out_port[c*3 +: 3]);
    endfunction

    initial begin
        int dstList[4] = '{5, 7, 0, 1};
        int expList[4] = '{0, 2, 4, 1};

        clearInputs();
        rst = 1'b1;
        runCycle();
        runCycle();
        checkOutput("reset_valid", 32'(out_valid), 0);
        checkOutput("reset_port", 32'(out_port), 0);
        checkOutput("reset_err", 32'(err), 0);

        rst = 1'b0;
        router_add = AW'(5);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, dstList[i], 0);
            checkOutput($sformatf("single_valid_%0d", i), 32'(out_valid[0]), 1);
            checkOutput($sformatf("single_port_%0d", i), 32'(portOf(0)), 32'(expList[i]));
        end
        clearInputs();
        runCycle();
        checkOutput("valid_falls", 32'(out_valid[0]), 0);

        applyStimulus(0, 1, 0, 7, 0);
        checkOutput("pkt_head", 32'(portOf(0)), 2);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pkt_body1", 32'(portOf(0)), 2);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pkt_body2", 32'(portOf(0)), 2);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("pkt_tail", 32'(portOf(0)), 2);
        checkOutput("pkt_tail_flag", 32'(out_tail[0]), 1);
        checkOutput("pkt_no_err", 32'(err[0]), 0);

        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle_body_port", 32'(portOf(0)), 7);
        checkOutput("idle_body_err", 32'(err[0]), 1);
        clearInputs();
        repeat (3) runCycle();
        checkOutput("err_sticky", 32'(err[0]), 1);

`ifdef ROUTE_YX_EN
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("xy_west", 32'(portOf(1)), 4);
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("yx_north", 32'(portOf(1)), 1);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("yx_locked", 32'(portOf(1)), 1);
`endif

        applyStimulus(3, 1, 0, 13, 0);
        checkOutput("bad_y_port", 32'(portOf(3)), 7);
        checkOutput("bad_y_err", 32'(err[3]), 1);
        applyStimulus(3, 0, 1, 5, 0);
        checkOutput("bad_y_stays_idle", 32'(portOf(3)), 7);

        clearInputs();
        out_ready[4] = 1'b0;
        setFlit(4, 1, 0, 7, 0);
        runCycle();
        checkOutput("bp_first", 32'(portOf(4)), 2);
        for (int i = 0; i < 3; i++) begin
            clearInputs();
            out_ready[4] = 1'b0;
            setFlit(4, 0, 1, 0, 0);
            runCycle();
            checkOutput($sformatf("bp_ready_%0d", i), 32'(in_ready[4]), 0);
            checkOutput($sformatf("bp_hold_port_%0d", i), 32'(portOf(4)), 2);
            checkOutput($sformatf("bp_hold_tail_%0d", i), 32'(out_tail[4]), 0);
        end
        clearInputs();
        setFlit(4, 0, 1, 0, 0);
        runCycle();
        checkOutput("bp_second_valid", 32'(out_valid[4]), 1);
        checkOutput("bp_second_tail", 32'(out_tail[4]), 1);
        checkOutput("bp_second_port", 32'(portOf(4)), 2);
        clearInputs();
        runCycle();
        checkOutput("bp_drained", 32'(out_valid[4]), 0);

        clearInputs();
        setFlit(2, 1, 0, 7, 0);
        setFlit(0, 1, 1, 7, 0);
        runCycle();
        clearInputs();
        setFlit(2, 0, 0, 7, 0);
        setFlit(0, 1, 1, 0, 0);
        rst = 1'b1;
        runCycle();
        checkOutput("midrst_valid", 32'(out_valid), 0);
        checkOutput("midrst_port", 32'(out_port), 0);
        checkOutput("midrst_tail", 32'(out_tail), 0);
        checkOutput("midrst_err", 32'(err), 0);
        rst = 1'b0;
        clearInputs();
        setFlit(2, 0, 0, 7, 0);
        setFlit(0, 1, 1, 1, 0);
        runCycle();
        checkOutput("postrst_body_port", 32'(portOf(2)), 7);
        checkOutput("postrst_body_err", 32'(err[2]), 1);
        checkOutput("postrst_ch0_port", 32'(portOf(0)), 1);

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (rst)
                router_add = AW'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
            for (int c = 0; c < CH; c++) begin
                in_valid[c]  = ($urandom_range(0, 3) != 0);
                in_head[c]   = m_locked[c] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) != 0);
                in_tail[c]   = ($urandom_range(0, 2) == 0);
                in_dst[c*AW +: AW] = AW'($urandom_range(0, 15));
                yx_drv[c]    = 1'($urandom_range(0, 1));
                out_ready[c] = ($urandom_range(0, 3) != 0);
            end
            runCycle();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
